// File: rtl/ace_rr_arbiter_pkg.sv
// +------------------------------------------------------------------------+
// | ace_arb_pkg : shared types, widths and helpers for ace_rr_arbiter      |
// | rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

package ace_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int IDX_W = 5;
  localparam int CNT_W = 16;

  // Wraps at the real master count rather than at 2**IDX_W.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
    return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ace_rr_arbiter_if.sv
// +------------------------------------------------------------------------+
// | ace_rr_arbiter_if : requester side and downstream address channel      |
// | rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

interface ace_rr_arbiter_if
  import ace_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 8,
  parameter int ADDR_W      = 32
);

  logic [NUM_MASTERS-1:0]        req;
  logic [NUM_MASTERS*ADDR_W-1:0] req_addr;
  logic [NUM_MASTERS-1:0]        gnt_ack;
  logic                          m_valid;
  logic [ADDR_W-1:0]             m_addr;
  logic [IDX_W-1:0]              m_id;
  logic                          m_ready;

  modport slave (
    input  req, req_addr, m_ready,
    output gnt_ack, m_valid, m_addr, m_id
  );

  modport master (
    output req, req_addr, m_ready,
    input  gnt_ack, m_valid, m_addr, m_id
  );

endinterface

`default_nettype wire

// File: rtl/ace_rr_arbiter_rr_pick.sv
// +------------------------------------------------------------------------+
// | rr_pick : combinational round-robin pick, lowest index at/after rr_ptr |
// | rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module rr_pick
  import ace_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 8
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic                   valid,
  output logic [IDX_W-1:0]       idx,
  output logic [NUM_MASTERS-1:0] onehot
);

  logic             hi_valid;
  logic             lo_valid;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Descending scan so the last hit is the lowest index.
  always_comb begin
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_valid = 1'b1;
        lo_idx   = IDX_W'(i);
        if (i >= int'(rr_ptr)) begin
          hi_valid = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    valid = lo_valid;
    idx   = hi_valid ? hi_idx : lo_idx;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      onehot[i] = lo_valid && (int'(idx) == i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ace_rr_arbiter.sv
// +------------------------------------------------------------------------+
// | ace_rr_arbiter : round-robin arbiter onto one ACE address channel      |
// | optional macro ACE_RR_ARB_STATS_EN adds per-master grant counters       |
// | rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module ace_rr_arbiter
  import ace_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 8,
  parameter int ADDR_W      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  ace_rr_arbiter_if.slave              bus
`ifdef ACE_RR_ARB_STATS_EN
  ,
  output logic [NUM_MASTERS*CNT_W-1:0] grant_cnt
`endif
);

  arb_state_e             state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       m_id_q;
  logic [NUM_MASTERS-1:0] gnt_oh;
  logic                   m_valid_q;
  logic [ADDR_W-1:0]      m_addr_q;

  logic                   handshake;
  logic [NUM_MASTERS-1:0] pick_req;
  logic [IDX_W-1:0]       pick_ptr;
  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;
  logic [NUM_MASTERS-1:0] pick_oh;
  logic [ADDR_W-1:0]      pick_addr;

  assign handshake = (state == BUSY) && bus.m_ready && !rst;

  // In BUSY the picker already looks at the post-handshake pointer so the
  // next grant can load on the same edge with no idle bubble.
  always_comb begin
    if (state == BUSY) begin
      pick_req = bus.req & ~gnt_oh;
      pick_ptr = wrap_inc(m_id_q, NUM_MASTERS);
    end else begin
      pick_req = bus.req;
      pick_ptr = rr_ptr;
    end
  end

  rr_pick #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_pick (
    .req    (pick_req),
    .rr_ptr (pick_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_oh[i]) begin
        pick_addr = pick_addr | bus.req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_oh    <= '0;
      m_valid_q <= 1'b0;
      m_addr_q  <= '0;
      m_id_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt_oh    <= pick_oh;
            m_id_q    <= pick_idx;
            m_addr_q  <= pick_addr;
            m_valid_q <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (bus.m_ready) begin
            rr_ptr <= pick_ptr;
            if (pick_valid) begin
              gnt_oh   <= pick_oh;
              m_id_q   <= pick_idx;
              m_addr_q <= pick_addr;
            end else begin
              gnt_oh    <= '0;
              m_valid_q <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_ack = handshake ? gnt_oh : '0;
  assign bus.m_valid = m_valid_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_id    = m_id_q;

`ifdef ACE_RR_ARB_STATS_EN
  generate
    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_stats
      logic [CNT_W-1:0] cnt;
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt <= '0;
        end else if (handshake && gnt_oh[i] && (cnt != '1)) begin
          cnt <= cnt + 1'b1;
        end
      end
      assign grant_cnt[i*CNT_W +: CNT_W] = cnt;
    end
  endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_ace_rr_arbiter.sv
// +------------------------------------------------------------------------+
// | tb_ace_rr_arbiter : directed self-checking bench for ace_rr_arbiter     |
// | rev 1.0                                                                |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_ace_rr_arbiter;
  import ace_arb_pkg::*;

  localparam int NM = 8;
  localparam int AW = 32;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  ace_rr_arbiter_if #(.NUM_MASTERS(NM), .ADDR_W(AW)) bus ();

`ifdef ACE_RR_ARB_STATS_EN
  logic [NM*CNT_W-1:0] grant_cnt;
`endif

  ace_rr_arbiter #(
    .NUM_MASTERS (NM),
    .ADDR_W      (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef ACE_RR_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.m_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.req = '0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < NM; i++) bus.req_addr[i*AW +: AW] = 32'hA000_0000 + 32'(i * 256);

    // 1: reset state and quiet idle
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_valid", 64'(bus.m_valid), 64'h0);
    check("rst_gnt",   64'(bus.gnt_ack), 64'h0);
    check("rst_id",    64'(bus.m_id),    64'h0);
    check("rst_addr",  64'(bus.m_addr),  64'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idle_valid", 64'(bus.m_valid), 64'h0);
      check("idle_gnt",   64'(bus.gnt_ack), 64'h0);
    end

    // 2: req=0x24 -> 2 then 5 back-to-back, then IDLE
    bus.req = 8'h24;
    bus.m_ready = 1'b1;
    tick();
    #1;
    check("b2b_id0",   64'(bus.m_id),    64'd2);
    check("b2b_addr0", 64'(bus.m_addr),  64'hA000_0200);
    check("b2b_gnt0",  64'(bus.gnt_ack), 64'h04);
    bus.req = 8'h20;
    tick();
    #1;
    check("b2b_valid1", 64'(bus.m_valid), 64'h1);
    check("b2b_id1",    64'(bus.m_id),    64'd5);
    check("b2b_addr1",  64'(bus.m_addr),  64'hA000_0500);
    check("b2b_gnt1",   64'(bus.gnt_ack), 64'h20);
    bus.req = 8'h00;
    tick();
    #1;
    check("b2b_idle", 64'(bus.m_valid), 64'h0);
    check("b2b_nogn", 64'(bus.gnt_ack), 64'h0);

    // 3: all requesting -> 0..7,0
    do_reset();
    bus.req = 8'hFF;
    bus.m_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      #1;
      check("rr_valid", 64'(bus.m_valid), 64'h1);
      check("rr_id",    64'(bus.m_id),    64'(k % 8));
      check("rr_gnt",   64'(bus.gnt_ack), 64'(8'h01 << (k % 8)));
    end

    // 1b: reset while BUSY drops the transfer without an ack
    rst = 1'b1;
    #1;
    check("rstb_gnt", 64'(bus.gnt_ack), 64'h0);
    tick();
    check("rstb_valid", 64'(bus.m_valid), 64'h0);
    check("rstb_id",    64'(bus.m_id),    64'h0);
    rst = 1'b0;
    bus.req = '0;
    bus.m_ready = 1'b0;
    tick();

    // 4: stall with m_ready low; output stays stable
    bus.req = 8'h01;
    tick();
    #1;
    check("stall_valid", 64'(bus.m_valid), 64'h1);
    check("stall_id",    64'(bus.m_id),    64'h0);
    bus.req_addr[0 +: AW] = 32'hDEAD_BEEF;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_addr", 64'(bus.m_addr),  64'hA000_0000);
      check("stall_gnt",  64'(bus.gnt_ack), 64'h0);
      check("stall_v",    64'(bus.m_valid), 64'h1);
      tick();
    end
    bus.m_ready = 1'b1;
    #1;
    check("stall_ack", 64'(bus.gnt_ack), 64'h01);
    tick();
    bus.req = '0;
    bus.req_addr[0 +: AW] = 32'hA000_0000;
    #1;
    check("stall_idle", 64'(bus.m_valid), 64'h0);

    // 5: after grant to 6, req=0x41 wraps to 0
    do_reset();
    bus.req = 8'h40;
    bus.m_ready = 1'b1;
    tick();
    #1;
    check("wrap_id6", 64'(bus.m_id),    64'd6);
    check("wrap_g6",  64'(bus.gnt_ack), 64'h40);
    bus.req = 8'h00;
    tick();
    bus.req = 8'h41;
    tick();
    #1;
    check("wrap_id0",  64'(bus.m_id),    64'd0);
    check("wrap_a0",   64'(bus.m_addr),  64'hA000_0000);
    check("wrap_g0",   64'(bus.gnt_ack), 64'h01);
    bus.req = 8'h40;
    tick();
    #1;
    check("wrap_b2b6", 64'(bus.m_id),    64'd6);
    check("wrap_v6",   64'(bus.m_valid), 64'h1);
    bus.req = 8'h00;
    tick();
    #1;
    check("wrap_idle", 64'(bus.m_valid), 64'h0);

`ifdef ACE_RR_ARB_STATS_EN
    // 6: counter for master 3 saturates, others untouched
    do_reset();
    bus.req = 8'h08;
    bus.m_ready = 1'b1;
    for (int k = 0; k < 2 * 65540; k++) tick();
    bus.req = 8'h00;
    tick();
    tick();
    check("stats_lo", grant_cnt[63:0],   64'hFFFF_0000_0000_0000);
    check("stats_hi", grant_cnt[127:64], 64'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
